// File: rtl/sl_tx_pkg.sv
// Shared types and helpers for the SL transmit scheduler.
// Holds the FSM state type, word bundle and config-word helpers.
package sl_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        CFG,
        LOAD,
        WAIT_START,
        WAIT_DONE,
        RELEASE
    } sched_state_t;

    localparam logic [5:0] SL_MIN_LEN  = 6'd8;
    localparam logic [5:0] SL_MAX_LEN  = 6'd32;
    localparam logic [2:0] SL_MAX_FREQ = 3'd5;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  len;
        logic [2:0]  freq;
    } sl_word_t;

    function automatic logic [9:0] sl_cfg_word(
        input logic [5:0] len,
        input logic [2:0] freq
    );
        return {freq, 1'b0, len};
    endfunction

    function automatic logic sl_cfg_legal(
        input logic [5:0] len,
        input logic [2:0] freq
    );
        return !len[0]
            && (len >= SL_MIN_LEN)
            && (len <= SL_MAX_LEN)
            && (freq <= SL_MAX_FREQ);
    endfunction

endpackage

// File: rtl/sl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req starting at ptr and returns the first hit.
module sl_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     idx,
    output logic               any
);

    // first requester at or after ptr, wrapping around
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[IDW'(j)]) begin
                any             = 1'b1;
                idx             = IDW'(j);
                grant[IDW'(j)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sl_tx_scheduler.sv
// Shares one SL transmitter between NUM_REQ requesters.
// Optional config-skip cache: define SL_TX_SCHED_CFG_SKIP_EN.
module sl_tx_scheduler
    import sl_tx_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16,
    parameter int IDW           = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*32-1:0] req_data,
    input  logic [NUM_REQ*6-1:0] req_len,
    input  logic [NUM_REQ*3-1:0] req_freq,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   err,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic [9:0]           tx_wr_config_w,
    output logic                 tx_wr_config_enable,
    output logic [31:0]          tx_data_a,
    output logic                 tx_send_imm,
    input  logic                 tx_send_in_process
);

    localparam int CW = $clog2(START_TIMEOUT + 1);

    sched_state_t         state;
    sched_state_t         state_nxt;
    logic [IDW-1:0]       ptr;
    sl_word_t             word;
    sl_word_t             sel_word;
    logic [CW-1:0]        cnt;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDW-1:0]       arb_idx;
    logic                 arb_any;
    logic                 done_hit;
    logic                 fail_hit;
    logic                 cfg_skip;
    logic [9:0]           cfg_now;
    logic                 legal;
    logic [NUM_REQ-1:0]   grant_oh;

    sl_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign cfg_now  = sl_cfg_word(word.len, word.freq);
    assign legal    = sl_cfg_legal(word.len, word.freq);
    assign grant_oh = NUM_REQ'(1) << grant_id;

    // pick the winning requester's word slices
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDW'(i)) begin
                sel_word.data = req_data[32*i +: 32];
                sel_word.len  = req_len[6*i +: 6];
                sel_word.freq = req_freq[3*i +: 3];
            end
        end
    end

`ifdef SL_TX_SCHED_CFG_SKIP_EN
    logic [9:0] cache_w;
    logic       cache_v;

    // remember the last config word written to the transmitter
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_w <= '0;
            cache_v <= 1'b0;
        end else if (state == CFG) begin
            cache_w <= cfg_now;
            cache_v <= 1'b1;
        end
    end

    assign cfg_skip = cache_v && (cache_w == cfg_now);
`else
    assign cfg_skip = 1'b0;
`endif

    // next-state decode plus ack/err request flags
    always_comb begin
        state_nxt = state;
        done_hit  = 1'b0;
        fail_hit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (arb_any) state_nxt = CHECK;
            end
            CHECK: begin
                if (!legal) begin
                    fail_hit  = 1'b1;
                    state_nxt = RELEASE;
                end else if (cfg_skip) begin
                    state_nxt = LOAD;
                end else begin
                    state_nxt = CFG;
                end
            end
            CFG:  state_nxt = LOAD;
            LOAD: state_nxt = WAIT_START;
            WAIT_START: begin
                if (tx_send_in_process) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CW'(START_TIMEOUT - 1)) begin
                    fail_hit  = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            WAIT_DONE: begin
                if (!tx_send_in_process) begin
                    done_hit  = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state, grant, latched word, start counter and result pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            word     <= '0;
            cnt      <= '0;
            ack      <= '0;
            err      <= '0;
        end else begin
            state <= state_nxt;
            ack   <= done_hit ? grant_oh : '0;
            err   <= fail_hit ? grant_oh : '0;
            if (state == IDLE && arb_any) begin
                grant_id <= arb_idx;
                word     <= sel_word;
            end
            // cnt holds cycles elapsed since the send strobe
            if (state == LOAD) begin
                cnt <= CW'(1);
            end else if (state == WAIT_START) begin
                cnt <= cnt + CW'(1);
            end
            if (state == RELEASE) begin
                ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
            end
        end
    end

    assign busy                = (state != IDLE);
    assign tx_wr_config_enable = (state == CFG);
    assign tx_wr_config_w      = (state == CFG) ? cfg_now : '0;
    assign tx_send_imm         = (state == LOAD);
    assign tx_data_a           = (state == LOAD) ? word.data : '0;

endmodule

// File: tb/tb_sl_tx_scheduler.sv
// Directed bench for sl_tx_scheduler with a simple transmitter stub.
// Covers reset, config/send, arbitration, rejects, timeout, mid-word reset.
module tb_sl_tx_scheduler;

    localparam int N  = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*32-1:0] req_data;
    logic [N*6-1:0]  req_len;
    logic [N*3-1:0]  req_freq;
    logic [N-1:0]    ack;
    logic [N-1:0]    err;
    logic            busy;
    logic [1:0]      grant_id;
    logic [9:0]      tx_wr_config_w;
    logic            tx_wr_config_enable;
    logic [31:0]     tx_data_a;
    logic            tx_send_imm;
    logic            sip;

    int n_cmp = 0;
    int n_bad = 0;

    bit stub_on = 1'b1;
    int shigh   = 5;
    int scnt    = 0;

    int cfg_seen  = 0;
    int send_seen = 0;
    int overlap   = 0;
    int stray     = 0;

    sl_tx_scheduler #(
        .NUM_REQ       (N),
        .START_TIMEOUT (TO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req                 (req),
        .req_data            (req_data),
        .req_len             (req_len),
        .req_freq            (req_freq),
        .ack                 (ack),
        .err                 (err),
        .busy                (busy),
        .grant_id            (grant_id),
        .tx_wr_config_w      (tx_wr_config_w),
        .tx_wr_config_enable (tx_wr_config_enable),
        .tx_data_a           (tx_data_a),
        .tx_send_imm         (tx_send_imm),
        .tx_send_in_process  (sip)
    );

    always #5 clk = ~clk;

    // transmitter stub: busy rises 2 cycles after send, stays shigh cycles
    always @(posedge clk) begin
        if (!stub_on) scnt <= 0;
        else if (tx_send_imm) scnt <= 1;
        else if (scnt != 0 && scnt < shigh + 2) scnt <= scnt + 1;
        else scnt <= 0;
    end

    assign sip = stub_on && (scnt >= 2) && (scnt < shigh + 2);

    // protocol monitor
    always @(negedge clk) begin
        if (tx_wr_config_enable) cfg_seen++;
        if (tx_send_imm) send_seen++;
        if (tx_send_imm && sip) overlap++;
        if ((ack & err) != 0) stray++;
        if (((ack | err) & ~(N'(1) << grant_id)) != 0) stray++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int i, input logic [31:0] d,
                            input logic [5:0] l, input logic [2:0] f);
        req_data[32*i +: 32] = d;
        req_len[6*i +: 6]    = l;
        req_freq[3*i +: 3]   = f;
    endtask

    task automatic wait_result(output logic [N-1:0] a, output logic [N-1:0] e,
                               output int cyc);
        cyc = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            cyc++;
            if ((ack | err) != 0) break;
        end
        a = ack;
        e = err;
        check("result_seen", 32'((ack | err) != 0), 1);
    endtask

    task automatic wait_send(output int cyc);
        cyc = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            cyc++;
            if (tx_send_imm) break;
        end
        check("send_seen", 32'(tx_send_imm), 1);
    endtask

    logic [N-1:0] a;
    logic [N-1:0] e;
    int           cyc;
    int           s0;
    int           c0;
    int           ov0;
    logic [5:0]   bad_len [3];
    logic [2:0]   bad_freq [3];

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        req_len  = '0;
        req_freq = '0;
        step();
        step();

        // reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_gid", 32'(grant_id), 0);
        check("rst_cfg_en", 32'(tx_wr_config_enable), 0);
        check("rst_send", 32'(tx_send_imm), 0);
        check("rst_data", tx_data_a, 0);
        check("rst_cfg_w", 32'(tx_wr_config_w), 0);
        rst = 1'b0;
        step();

        // single legal word from requester 0
        set_word(0, 32'h00A5_5A3C, 6'd16, 3'd2);
        req = 4'b0001;
        step();
        check("t1_busy", 32'(busy), 1);
        check("t1_gid", 32'(grant_id), 0);
        step();
        check("t1_cfg_en", 32'(tx_wr_config_enable), 1);
        check("t1_cfg_w", 32'(tx_wr_config_w), 32'h110);
        check("t1_send_early", 32'(tx_send_imm), 0);
        step();
        check("t1_send", 32'(tx_send_imm), 1);
        check("t1_data", tx_data_a, 32'h00A5_5A3C);
        check("t1_cfg_off", 32'(tx_wr_config_w), 0);
        wait_result(a, e, cyc);
        check("t1_ack", 32'(a), 32'h1);
        check("t1_err", 32'(e), 0);
        req = '0;
        step();
        check("t1_ack_pulse", 32'(ack), 0);
        check("t1_idle", 32'(busy), 0);

        // illegal words from requester 1
        bad_len[0]  = 6'd9;  bad_freq[0] = 3'd2;
        bad_len[1]  = 6'd34; bad_freq[1] = 3'd2;
        bad_len[2]  = 6'd16; bad_freq[2] = 3'd6;
        s0 = send_seen;
        for (int i = 0; i < 3; i++) begin
            set_word(1, 32'h1234_5678, bad_len[i], bad_freq[i]);
            req = 4'b0010;
            wait_result(a, e, cyc);
            check("ill_err", 32'(e), 32'h2);
            check("ill_ack", 32'(a), 0);
            check("ill_lat", 32'(cyc), 2);
            req = '0;
            step();
            check("ill_idle", 32'(busy), 0);
        end
        check("ill_no_send", 32'(send_seen - s0), 0);

        // start timeout on requester 2, requester 3 arrives while busy
        stub_on = 1'b0;
        set_word(2, 32'hDEAD_BEEF, 6'd16, 3'd0);
        req = 4'b0100;
        wait_send(cyc);
        check("to_send_lat", 32'(cyc), 3);
        set_word(3, 32'h0BAD_F00D, 6'd20, 3'd3);
        req = 4'b1100;
        wait_result(a, e, cyc);
        check("to_err", 32'(e), 32'h4);
        check("to_cycles", 32'(cyc), TO);
        check("to_ack", 32'(a), 0);
        req     = 4'b1000;
        stub_on = 1'b1;
        wait_result(a, e, cyc);
        check("to_next_ack", 32'(a), 32'h8);
        check("to_next_err", 32'(e), 0);
        req = '0;
        step();

        // all four requesting: strict rotation
        set_word(0, 32'h1111_0000, 6'd8,  3'd0);
        set_word(1, 32'h2222_0000, 6'd10, 3'd1);
        set_word(2, 32'h3333_0000, 6'd12, 3'd4);
        set_word(3, 32'h4444_0000, 6'd32, 3'd5);
        ov0 = overlap;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_result(a, e, cyc);
            check("rot_ack", 32'(a), 32'(1 << (k % 4)));
            check("rot_err", 32'(e), 0);
            check("rot_sip_low", 32'(sip), 0);
        end
        req = '0;
        step();
        check("rot_overlap", 32'(overlap - ov0), 0);

        // reset during WAIT_DONE drops the word, req0 re-granted
        req = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            step();
            if (sip) break;
        end
        check("mr_sip_seen", 32'(sip), 1);
        step();
        rst = 1'b1;
        step();
        check("mr_busy", 32'(busy), 0);
        check("mr_ack", 32'(ack), 0);
        check("mr_err", 32'(err), 0);
        check("mr_send", 32'(tx_send_imm), 0);
        check("mr_gid", 32'(grant_id), 0);
        rst = 1'b0;
        wait_result(a, e, cyc);
        check("mr_ack_again", 32'(a), 32'h1);
        check("mr_err_again", 32'(e), 0);
        req = '0;
        step();

        // two identical configs back to back
        c0 = cfg_seen;
        set_word(2, 32'hCAFE_0001, 6'd24, 3'd1);
        req = 4'b0100;
        wait_send(cyc);
        check("sk_lat1", 32'(cyc), 3);
        wait_result(a, e, cyc);
        check("sk_ack1", 32'(a), 32'h4);
        req = '0;
        step();
        set_word(2, 32'hCAFE_0002, 6'd24, 3'd1);
        req = 4'b0100;
        wait_send(cyc);
`ifdef SL_TX_SCHED_CFG_SKIP_EN
        check("sk_lat2", 32'(cyc), 2);
`else
        check("sk_lat2", 32'(cyc), 3);
`endif
        check("sk_data2", tx_data_a, 32'hCAFE_0002);
        wait_result(a, e, cyc);
        check("sk_ack2", 32'(a), 32'h4);
        req = '0;
        step();
`ifdef SL_TX_SCHED_CFG_SKIP_EN
        check("sk_cfg_count", 32'(cfg_seen - c0), 1);
`else
        check("sk_cfg_count", 32'(cfg_seen - c0), 2);
`endif

        check("stray_pulses", 32'(stray), 0);
        check("send_overlap", 32'(overlap), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
